// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (OP_AND .. OP_MUL)
//   - controller state encoding (S_IDLE, S_EXEC, S_DONE)
//   - flag bundle type {carry, zero, negative, overflow}
package alu_pkg;

    localparam logic [5:0] OP_AND  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_ANDI = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h04;
    localparam logic [5:0] OP_BGT  = 6'h08;
    localparam logic [5:0] OP_BLT  = 6'h09;
    localparam logic [5:0] OP_BEQ  = 6'h0A;
    localparam logic [5:0] OP_BNE  = 6'h0B;
    localparam logic [5:0] OP_SLL  = 6'h0C;
    localparam logic [5:0] OP_SRL  = 6'h0D;
    localparam logic [5:0] OP_MUL  = 6'h0E;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: multi-cycle engine for SLL, SRL and MUL.
// Ports:
//   clk, reset       clock, async active-high reset
//   start            load operands and begin (only for SLL/SRL with amt>0, or MUL)
//   op               opcode captured at start
//   a, b             operands; b[SHW-1:0] is the shift amount
//   busy             iteration in progress
//   done             the current cycle performs the last step
//   prod_lo/prod_hi  value the accumulator takes at the end of this cycle
//                    (final result when done is high)
import alu_pkg::*;

module alu_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = SHW + 1;

    logic [5:0]       op_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [WIDTH:0]   sum;
    logic [CNT_W-1:0] count;

    // MUL: {acc_hi,acc_lo} starts as {0,multiplier}; each step conditionally
    // adds the multiplicand to the upper half and shifts the pair right.
    always_comb begin
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        nxt_hi = acc_hi;
        nxt_lo = acc_lo;
        case (op_q)
            OP_SLL:  nxt_lo = acc_lo << 1;
            OP_SRL:  nxt_lo = acc_lo >> 1;
            default: {nxt_hi, nxt_lo} = {sum, acc_lo[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= '0;
        end else if (start) begin
            op_q   <= op;
            mcand  <= a;
            acc_hi <= '0;
            if (op == OP_MUL) begin
                acc_lo <= b;
                count  <= CNT_W'(WIDTH);
            end else begin
                acc_lo <= a;
                count  <= {1'b0, b[SHW-1:0]};
            end
        end else if (busy) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            count  <= count - CNT_W'(1);
        end
    end

    assign busy    = (count != '0);
    assign done    = (count == CNT_W'(1));
    assign prod_lo = nxt_lo;
    assign prod_hi = nxt_hi;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with valid/ready handshake on input and output.
// Single-cycle: AND/ANDI, ADD/ADDI, SUB, BGT/BLT/BEQ/BNE. Multi-cycle: SLL/SRL/MUL.
// Ports:
//   clk, reset                        clock, async active-high reset
//   in_valid/in_ready                 op accepted when both high
//   A, B, opcode                      operands and operation (latched at accept)
//   out_valid/out_ready               result taken when both high; outputs held until then
//   result                            registered result
//   carry, zero, negative, overflow   registered flags
//   taken                             branch decision (branch opcodes only)
//   illegal                           unknown opcode (result 0, zero 1)
//
// state  | meaning
// S_IDLE | no op in flight, ready to accept
// S_EXEC | iterative op running, in_ready low
// S_DONE | result presented, waiting for out_ready
import alu_pkg::*;

module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             taken,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic             accept, is_iter;
    logic             iter_busy, iter_done;
    logic [WIDTH-1:0] prod_lo, prod_hi;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_result;
    alu_flags_t       sc_flags, it_flags;
    logic             sc_taken, sc_illegal;

    assign in_ready = !reset && !iter_busy &&
                      ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    // A zero shift amount has nothing to iterate and completes like a single-cycle op.
    assign is_iter  = (opcode == OP_MUL) ||
                      (((opcode == OP_SLL) || (opcode == OP_SRL)) && (B[SHW-1:0] != '0));

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_iter),
        .op      (opcode),
        .a       (A),
        .b       (B),
        .busy    (iter_busy),
        .done    (iter_done),
        .prod_lo (prod_lo),
        .prod_hi (prod_hi)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = is_iter ? S_EXEC : S_DONE;
            S_EXEC:  if (iter_done) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = accept ? (is_iter ? S_EXEC : S_DONE) : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sc_result  = '0;
        sc_flags   = '0;
        sc_taken   = 1'b0;
        sc_illegal = 1'b0;
        add_full   = {1'b0, A} + {1'b0, B};
        diff       = A - B;
        case (opcode)
            OP_AND, OP_ANDI: sc_result = A & B;
            OP_ADD, OP_ADDI: begin
                sc_result         = add_full[WIDTH-1:0];
                sc_flags.carry    = add_full[WIDTH];
                sc_flags.overflow = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB, OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
                sc_result         = diff;
                sc_flags.carry    = (A < B);
                sc_flags.overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
                case (opcode)
                    OP_BGT:  sc_taken = ($signed(A) > $signed(B));
                    OP_BLT:  sc_taken = ($signed(A) < $signed(B));
                    OP_BEQ:  sc_taken = (A == B);
                    OP_BNE:  sc_taken = (A != B);
                    default: sc_taken = 1'b0;
                endcase
            end
            // Only reached here with a zero shift amount.
            OP_SLL, OP_SRL, OP_MUL: sc_result = A;
            default: sc_illegal = 1'b1;
        endcase
        sc_flags.zero     = (sc_result == '0);
        sc_flags.negative = sc_result[WIDTH-1];
    end

    // prod_hi stays zero for shifts, so it doubles as the MUL overflow source.
    always_comb begin
        it_flags          = '0;
        it_flags.carry    = |prod_hi;
        it_flags.overflow = |prod_hi;
        it_flags.zero     = (prod_lo == '0);
        it_flags.negative = prod_lo[WIDTH-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            taken     <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept && !is_iter) begin
            result    <= sc_result;
            carry     <= sc_flags.carry;
            zero      <= sc_flags.zero;
            negative  <= sc_flags.negative;
            overflow  <= sc_flags.overflow;
            taken     <= sc_taken;
            illegal   <= sc_illegal;
            out_valid <= 1'b1;
        end else if (iter_done) begin
            result    <= prod_lo;
            carry     <= it_flags.carry;
            zero      <= it_flags.zero;
            negative  <= it_flags.negative;
            overflow  <= it_flags.overflow;
            taken     <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
